// File: rtl/day10_pkg.sv
// Shared types, default widths and the trailing-zero helper for the day-10 button solver.
package day10_pkg;

  localparam int DEF_MAX_NUM_BUTTONS = 8;
  localparam int DEF_MAX_NUM_LIGHTS  = 10;
  localparam int DEF_TOTAL_W         = 32;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_e;

  // Index of the lowest set bit; an all-zero input yields 0.
  function automatic logic [5:0] ctz32(input logic [31:0] v);
    logic [5:0] r;
    r = 6'd0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) r = 6'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/day10_gray_flip_idx.sv
// Button index toggled when stepping the Gray-code enumeration from k to k+1.
module day10_gray_flip_idx
  import day10_pkg::*;
#(
  parameter int KW = 9,
  parameter int JW = 3
) (
  input  logic [KW-1:0] k_i,
  output logic [JW-1:0] j_o
);

  logic [31:0] kPlusOne;

  assign kPlusOne = 32'(k_i) + 32'd1;
  assign j_o      = JW'(ctz32(kPlusOne));

endmodule

// File: rtl/day10_min_press_solver.sv
// Minimum-press solver: enumerates button subsets in Gray order, one candidate per cycle.
module day10_min_press_solver
  import day10_pkg::*;
#(
  parameter int MAX_NUM_BUTTONS   = DEF_MAX_NUM_BUTTONS,
  parameter int MAX_NUM_LIGHTS    = DEF_MAX_NUM_LIGHTS,
  parameter int MAX_NUM_BUTTONS_W = $clog2(MAX_NUM_BUTTONS + 1),
  parameter int MAX_NUM_PRESSES_W = MAX_NUM_BUTTONS_W,
  parameter int TOTAL_W           = DEF_TOTAL_W
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [MAX_NUM_BUTTONS_W-1:0]              in_num_buttons,
  input  logic [MAX_NUM_LIGHTS-1:0]                 in_target,
  input  logic [MAX_NUM_BUTTONS*MAX_NUM_LIGHTS-1:0] in_button_masks,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic                                      out_found,
  output logic [MAX_NUM_PRESSES_W-1:0]              min_button_presses,
  output logic [MAX_NUM_BUTTONS-1:0]                buttons_to_press,
  input  logic                                      clear_total,
  output logic [TOTAL_W-1:0]                        total_presses
);

  localparam int KW = MAX_NUM_BUTTONS + 1;
  localparam int JW = (MAX_NUM_BUTTONS > 1) ? $clog2(MAX_NUM_BUTTONS) : 1;
  localparam int NW = MAX_NUM_BUTTONS_W;
  localparam int L  = MAX_NUM_LIGHTS;

  state_e                          state_q, state_d;
  logic [NW-1:0]                   numButtons_q, numButtons_d;
  logic [L-1:0]                    target_q, target_d;
  logic [L-1:0]                    acc_q, acc_d;
  logic [MAX_NUM_BUTTONS*L-1:0]    masks_q, masks_d;
  logic [KW-1:0]                   k_q, k_d;
  logic [MAX_NUM_BUTTONS-1:0]      subset_q, subset_d;
  logic [MAX_NUM_BUTTONS-1:0]      bestSubset_q, bestSubset_d;
  logic [MAX_NUM_BUTTONS-1:0]      buttons_q, buttons_d;
  logic [NW-1:0]                   pop_q, pop_d;
  logic [NW-1:0]                   bestPop_q, bestPop_d;
  logic                            bestFound_q, bestFound_d;
  logic                            outValid_q, outValid_d;
  logic                            outFound_q, outFound_d;
  logic [MAX_NUM_PRESSES_W-1:0]    presses_q, presses_d;
  logic [TOTAL_W-1:0]              total_q, total_d;

  logic [JW-1:0]                   flipIdx;
  logic [KW-1:0]                   lastK;
  logic                            hit;
  logic                            accumulate;
  logic [TOTAL_W-1:0]              totalBase;
  logic [TOTAL_W:0]                sum;

  day10_gray_flip_idx #(
    .KW (KW),
    .JW (JW)
  ) u_flip (
    .k_i (k_q),
    .j_o (flipIdx)
  );

  assign lastK      = (KW'(1) << numButtons_q) - KW'(1);
  assign hit        = (acc_q == target_q) && (!bestFound_q || (pop_q < bestPop_q));
  assign accumulate = (state_q == DONE) && outValid_q && out_ready && outFound_q;

  // Strict '<' on pop keeps the first minimum met in Gray order.
  always_comb begin
    state_d      = state_q;
    numButtons_d = numButtons_q;
    target_d     = target_q;
    acc_d        = acc_q;
    masks_d      = masks_q;
    k_d          = k_q;
    subset_d     = subset_q;
    bestSubset_d = bestSubset_q;
    buttons_d    = buttons_q;
    pop_d        = pop_q;
    bestPop_d    = bestPop_q;
    bestFound_d  = bestFound_q;
    outValid_d   = outValid_q;
    outFound_d   = outFound_q;
    presses_d    = presses_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d      = SEARCH;
          numButtons_d = (in_num_buttons > NW'(MAX_NUM_BUTTONS)) ? NW'(MAX_NUM_BUTTONS)
                                                                 : in_num_buttons;
          target_d     = in_target;
          masks_d      = in_button_masks;
          k_d          = '0;
          acc_d        = '0;
          subset_d     = '0;
          pop_d        = '0;
          bestPop_d    = '1;
          bestFound_d  = 1'b0;
        end
      end
      SEARCH: begin
        if (hit) begin
          bestSubset_d = subset_q;
          bestPop_d    = pop_q;
          bestFound_d  = 1'b1;
        end
        if (k_q == lastK) begin
          state_d = DONE;
        end else begin
          acc_d             = acc_q ^ masks_q[flipIdx*L +: L];
          subset_d[flipIdx] = ~subset_q[flipIdx];
          pop_d             = subset_q[flipIdx] ? pop_q - NW'(1) : pop_q + NW'(1);
          k_d               = k_q + KW'(1);
        end
      end
      DONE: begin
        // First DONE cycle loads the result registers; out_valid follows one cycle later.
        if (!outValid_q) begin
          outValid_d = 1'b1;
          outFound_d = bestFound_q;
          presses_d  = bestFound_q ? MAX_NUM_PRESSES_W'(bestPop_q) : '0;
          buttons_d  = bestFound_q ? bestSubset_q : '0;
        end else if (out_ready) begin
          outValid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    totalBase = clear_total ? '0 : total_q;
    sum       = {1'b0, totalBase} + (TOTAL_W+1)'(presses_q);
    if (accumulate) total_d = sum[TOTAL_W] ? '1 : sum[TOTAL_W-1:0];
    else            total_d = totalBase;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      numButtons_q <= '0;
      target_q     <= '0;
      acc_q        <= '0;
      masks_q      <= '0;
      k_q          <= '0;
      subset_q     <= '0;
      bestSubset_q <= '0;
      buttons_q    <= '0;
      pop_q        <= '0;
      bestPop_q    <= '0;
      bestFound_q  <= 1'b0;
      outValid_q   <= 1'b0;
      outFound_q   <= 1'b0;
      presses_q    <= '0;
      total_q      <= '0;
    end else begin
      state_q      <= state_d;
      numButtons_q <= numButtons_d;
      target_q     <= target_d;
      acc_q        <= acc_d;
      masks_q      <= masks_d;
      k_q          <= k_d;
      subset_q     <= subset_d;
      bestSubset_q <= bestSubset_d;
      buttons_q    <= buttons_d;
      pop_q        <= pop_d;
      bestPop_q    <= bestPop_d;
      bestFound_q  <= bestFound_d;
      outValid_q   <= outValid_d;
      outFound_q   <= outFound_d;
      presses_q    <= presses_d;
      total_q      <= total_d;
    end
  end

  assign in_ready           = (state_q == IDLE);
  assign out_valid          = outValid_q;
  assign out_found          = outFound_q;
  assign min_button_presses = presses_q;
  assign buttons_to_press   = buttons_q;
  assign total_presses      = total_q;

endmodule

// File: tb/tb_day10_min_press_solver.sv
// Directed, table-driven bench for the day-10 solver; a second instance with TOTAL_W=4 checks saturation.
module tb_day10_min_press_solver;

  typedef struct {
    logic [3:0]  n;
    logic [9:0]  target;
    logic [79:0] masks;
    logic        expFound;
    logic [3:0]  expPresses;
    logic [7:0]  expButtons;
    int          effN;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, out_ready, clear_total;
  logic [3:0]  in_num_buttons;
  logic [9:0]  in_target;
  logic [79:0] in_button_masks;

  logic        in_ready, out_valid, out_found;
  logic [3:0]  min_button_presses;
  logic [7:0]  buttons_to_press;
  logic [31:0] total_presses;

  logic        sInReady, sOutValid, sOutFound;
  logic [3:0]  sPresses;
  logic [7:0]  sButtons;
  logic [3:0]  sTotal;

  int   checks = 0;
  int   errors = 0;
  int   modelTotal = 0;
  int   modelSat = 0;
  vec_t vecs[11];

  always #5 clk = ~clk;

  day10_min_press_solver dut (
    .clk (clk), .rst_n (rst_n),
    .in_valid (in_valid), .in_ready (in_ready),
    .in_num_buttons (in_num_buttons), .in_target (in_target), .in_button_masks (in_button_masks),
    .out_valid (out_valid), .out_ready (out_ready), .out_found (out_found),
    .min_button_presses (min_button_presses), .buttons_to_press (buttons_to_press),
    .clear_total (clear_total), .total_presses (total_presses)
  );

  day10_min_press_solver #(.TOTAL_W (4)) dutSat (
    .clk (clk), .rst_n (rst_n),
    .in_valid (in_valid), .in_ready (sInReady),
    .in_num_buttons (in_num_buttons), .in_target (in_target), .in_button_masks (in_button_masks),
    .out_valid (sOutValid), .out_ready (out_ready), .out_found (sOutFound),
    .min_button_presses (sPresses), .buttons_to_press (sButtons),
    .clear_total (clear_total), .total_presses (sTotal)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Accepts one machine and waits for its result, checking latency and result fields.
  task automatic applyStimulus(input vec_t v, input logic clrOnAccept);
    int cyc;
    bit seen;
    checkOutput("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid        = 1'b1;
    in_num_buttons  = v.n;
    in_target       = v.target;
    in_button_masks = v.masks;
    clear_total     = clrOnAccept;
    @(posedge clk); #1;
    in_valid        = 1'b0;
    clear_total     = 1'b0;
    in_num_buttons  = 4'd0;
    in_target       = ~v.target;
    in_button_masks = ~v.masks;
    if (clrOnAccept) begin
      modelTotal = 0;
      modelSat   = 0;
    end
    checkOutput("in_ready_busy", 32'(in_ready), 32'd0);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 600) begin
      @(posedge clk); #1;
      cyc++;
      if (out_valid) seen = 1'b1;
    end
    checkOutput("latency", 32'(cyc), 32'((1 << v.effN) + 1));
    checkOutput("found", 32'(out_found), 32'(v.expFound));
    checkOutput("presses", 32'(min_button_presses), 32'(v.expPresses));
    checkOutput("buttons", 32'(buttons_to_press), 32'(v.expButtons));
  endtask

  task automatic handshake(input vec_t v, input logic clr);
    out_ready   = 1'b1;
    clear_total = clr;
    @(posedge clk); #1;
    out_ready   = 1'b0;
    clear_total = 1'b0;
    if (clr) begin
      modelTotal = 0;
      modelSat   = 0;
    end
    if (v.expFound) begin
      modelTotal = modelTotal + int'(v.expPresses);
      modelSat   = modelSat + int'(v.expPresses);
      if (modelSat > 15) modelSat = 15;
    end
    checkOutput("out_valid_after_hs", 32'(out_valid), 32'd0);
    checkOutput("in_ready_after_hs", 32'(in_ready), 32'd1);
    checkOutput("total", total_presses, 32'(modelTotal));
    checkOutput("total_sat", 32'(sTotal), 32'(modelSat));
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int hits;
    vecs[0]  = '{4'd6, 10'h006, {20'h0, 10'h003, 10'h005, 10'h00C, 10'h004, 10'h00A, 10'h008},
                 1'b1, 4'd2, 8'h0A, 6};
    vecs[1]  = '{4'd2, 10'h001, {60'h0, 10'h004, 10'h002}, 1'b0, 4'd0, 8'h00, 2};
    vecs[2]  = '{4'd0, 10'h000, {70'h0, 10'h001}, 1'b1, 4'd0, 8'h00, 0};
    vecs[3]  = '{4'd0, 10'h001, {70'h0, 10'h001}, 1'b0, 4'd0, 8'h00, 0};
    vecs[4]  = '{4'd3, 10'h005, {50'h0, 10'h005, 10'h006, 10'h003}, 1'b1, 4'd1, 8'h04, 3};
    vecs[5]  = '{4'd3, 10'h000, {50'h0, 10'h005, 10'h006, 10'h003}, 1'b1, 4'd0, 8'h00, 3};
    vecs[6]  = '{4'd15, 10'h080, {10'h080, 10'h040, 10'h020, 10'h010, 10'h008, 10'h004, 10'h002,
                 10'h001}, 1'b1, 4'd1, 8'h80, 8};
    vecs[7]  = '{4'd1, 10'h002, {60'h0, 10'h002, 10'h001}, 1'b0, 4'd0, 8'h00, 1};
    vecs[8]  = '{4'd1, 10'h200, {70'h0, 10'h200}, 1'b1, 4'd1, 8'h01, 1};
    vecs[9]  = '{4'd5, 10'h01F, {30'h0, 10'h010, 10'h008, 10'h004, 10'h002, 10'h001},
                 1'b1, 4'd5, 8'h1F, 5};
    vecs[10] = '{4'd7, 10'h07F, {10'h0, 10'h040, 10'h020, 10'h010, 10'h008, 10'h004, 10'h002,
                 10'h001}, 1'b1, 4'd7, 8'h7F, 7};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clear_total = 1'b0;
    in_num_buttons = '0; in_target = '0; in_button_masks = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_found", 32'(out_found), 32'd0);
    checkOutput("rst_presses", 32'(min_button_presses), 32'd0);
    checkOutput("rst_buttons", 32'(buttons_to_press), 32'd0);
    checkOutput("rst_total", total_presses, 32'd0);
    checkOutput("rst_total_sat", 32'(sTotal), 32'd0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i], 1'b0);
      handshake(vecs[i], 1'b0);
    end

    // Reset in the middle of a search must abandon it with no result.
    in_valid = 1'b1; in_num_buttons = vecs[0].n; in_target = vecs[0].target;
    in_button_masks = vecs[0].masks;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    modelTotal = 0; modelSat = 0;
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_total", total_presses, 32'd0);
    hits = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (out_valid) hits++;
    end
    checkOutput("midrst_no_result", 32'(hits), 32'd0);

    // Backpressure: result held stable while out_ready stays low.
    applyStimulus(vecs[0], 1'b0);
    in_valid = 1'b1; in_num_buttons = vecs[1].n; in_target = vecs[1].target;
    in_button_masks = vecs[1].masks;
    repeat (20) begin
      @(posedge clk); #1;
      checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_found", 32'(out_found), 32'd1);
      checkOutput("bp_presses", 32'(min_button_presses), 32'd2);
      checkOutput("bp_buttons", 32'(buttons_to_press), 32'h0A);
    end
    in_valid = 1'b0;
    handshake(vecs[0], 1'b0);
    applyStimulus(vecs[9], 1'b0);
    handshake(vecs[9], 1'b0);
    checkOutput("bp_total_7", total_presses, 32'd7);
    applyStimulus(vecs[2], 1'b1);
    checkOutput("clr_on_accept", total_presses, 32'd0);
    handshake(vecs[2], 1'b0);

    // Clear coinciding with an accumulate leaves just the added value.
    applyStimulus(vecs[0], 1'b0);
    handshake(vecs[0], 1'b1);
    checkOutput("clr_plus_add", total_presses, 32'd2);

    clear_total = 1'b1;
    @(posedge clk); #1 clear_total = 1'b0;
    modelTotal = 0; modelSat = 0;
    checkOutput("clear_total", total_presses, 32'd0);
    checkOutput("clear_total_sat", 32'(sTotal), 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(vecs[10], 1'b0);
      handshake(vecs[10], 1'b0);
    end
    checkOutput("sat_final", 32'(sTotal), 32'd15);
    checkOutput("wide_final", total_presses, 32'd21);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
